// File: rtl/queue_word_packer.sv
// ---------------------------------------------------------------------------
// queue_word_packer
//
// Drain stage that sits behind the 8-entry byte queue controller. It pops
// bytes through the queue's first-word-fall-through interface, packs them
// little-endian into BYTES_PER_WORD-byte words, and presents each word on a
// valid/ready master port. A partial word is sent out early on an explicit
// flush pulse or after TIMEOUT idle cycles, so trailing bytes never stall.
//
// Parameters
//   BYTES_PER_WORD  bytes per output word (2..8)
//   TIMEOUT         idle cycles with a partial word before auto-flush (0 = off)
//
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_q_data     queue head byte, valid while !i_q_empty
//   i_q_empty    queue empty flag
//   o_q_deq      pop request; the byte on i_q_data is consumed this cycle
//   i_flush      single-cycle request to emit the current partial word
//   o_m_data     packed word, byte i on [8i+7:8i], unused lanes zero
//   o_m_count    number of valid bytes in o_m_data (1..BYTES_PER_WORD)
//   o_m_valid    word available
//   i_m_ready    consumer accepts the word when o_m_valid && i_m_ready
//   o_words_out  count of accepted words, wraps at 65535 -> 0
// ---------------------------------------------------------------------------
module queue_word_packer #(
  parameter int BYTES_PER_WORD = 4,
  parameter int TIMEOUT        = 16
) (
  input  logic                                    i_clk,
  input  logic                                    i_rst_n,
  input  logic [7:0]                              i_q_data,
  input  logic                                    i_q_empty,
  output logic                                    o_q_deq,
  input  logic                                    i_flush,
  output logic [8*BYTES_PER_WORD-1:0]             o_m_data,
  output logic [$clog2(BYTES_PER_WORD+1)-1:0]     o_m_count,
  output logic                                    o_m_valid,
  input  logic                                    i_m_ready,
  output logic [15:0]                             o_words_out
);

  localparam int DATA_W = 8 * BYTES_PER_WORD;
  localparam int CNT_W  = $clog2(BYTES_PER_WORD + 1);
  // The idle counter only ever has to reach TIMEOUT-1 before the flush fires.
  localparam int IDLE_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  localparam logic [CNT_W-1:0]  LAST_LANE  = CNT_W'(BYTES_PER_WORD - 1);
  localparam logic [CNT_W-1:0]  FULL_COUNT = CNT_W'(BYTES_PER_WORD);
  localparam logic [IDLE_W-1:0] IDLE_LAST  = IDLE_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_nextState;
  logic [CNT_W-1:0]    r_cnt;
  logic [IDLE_W-1:0]   r_idle;
  logic                r_flushPend;
  logic [DATA_W-1:0]   r_accum;
  logic [DATA_W-1:0]   w_accumNext;
  logic [DATA_W-1:0]   r_mData;
  logic [CNT_W-1:0]    r_mCount;
  logic                r_mValid;
  logic [15:0]         r_wordsOut;
  logic                w_timeout;
  logic                w_doFlush;
  logic                w_wordDone;

  // A pending flush request only matters when there is something to send.
  assign w_timeout  = (TIMEOUT != 0) && (r_idle == IDLE_LAST);
  assign w_doFlush  = (i_flush || r_flushPend || w_timeout) && (r_cnt != '0);
  assign w_wordDone = o_q_deq && (r_cnt == LAST_LANE);

  // Accumulator with the head byte dropped into the lane selected by r_cnt.
  always_comb begin
    w_accumNext = r_accum;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (r_cnt == CNT_W'(i)) begin
        w_accumNext[8*i +: 8] = i_q_data;
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= FILL;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: leave FILL when a word is completed or flushed, leave
  // HOLD once the consumer takes the word.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      FILL: begin
        if (w_doFlush || w_wordDone) begin
          w_nextState = HOLD;
        end
      end
      HOLD: begin
        if (i_m_ready) begin
          w_nextState = FILL;
        end
      end
      default: w_nextState = FILL;
    endcase
  end

  // Output logic: pop only while filling, never during a flush cycle, and
  // never while reset is held so the queue cannot lose a byte into reset.
  always_comb begin
    o_q_deq = 1'b0;
    if (i_rst_n && (r_state == FILL)) begin
      o_q_deq = !i_q_empty && !w_doFlush;
    end
  end

  // Datapath: accumulator, presented word, idle timer, pending flush and the
  // accepted-word counter. The accumulator is cleared whenever a word leaves
  // so that a later partial word carries zeros in its unused lanes.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt       <= '0;
      r_idle      <= '0;
      r_flushPend <= 1'b0;
      r_accum     <= '0;
      r_mData     <= '0;
      r_mCount    <= '0;
      r_mValid    <= 1'b0;
      r_wordsOut  <= '0;
    end else begin
      case (r_state)
        FILL: begin
          // Whether applied or not, a pending flush is consumed here.
          r_flushPend <= 1'b0;
          if (w_doFlush) begin
            r_mData  <= r_accum;
            r_mCount <= r_cnt;
            r_mValid <= 1'b1;
            r_cnt    <= '0;
            r_accum  <= '0;
            r_idle   <= '0;
          end else if (o_q_deq) begin
            r_idle <= '0;
            if (r_cnt == LAST_LANE) begin
              r_mData  <= w_accumNext;
              r_mCount <= FULL_COUNT;
              r_mValid <= 1'b1;
              r_cnt    <= '0;
              r_accum  <= '0;
            end else begin
              r_accum <= w_accumNext;
              r_cnt   <= r_cnt + CNT_W'(1);
            end
          end else if ((r_cnt != '0) && i_q_empty) begin
            r_idle <= r_idle + IDLE_W'(1);
          end
        end
        HOLD: begin
          if (i_flush) begin
            r_flushPend <= 1'b1;
          end
          if (r_mValid && i_m_ready) begin
            r_mValid   <= 1'b0;
            r_wordsOut <= r_wordsOut + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_m_data    = r_mData;
  assign o_m_count   = r_mCount;
  assign o_m_valid   = r_mValid;
  assign o_words_out = r_wordsOut;

endmodule

// File: tb/tb_queue_word_packer.sv
// ---------------------------------------------------------------------------
// tb_queue_word_packer
//
// Directed bench for queue_word_packer (4 bytes per word, 16-cycle timeout).
// A small byte-queue model feeds the DUT; inputs change 1 time unit after
// each rising edge and outputs are sampled after that.
// ---------------------------------------------------------------------------
module tb_queue_word_packer;

  localparam int BPW = 4;
  localparam int TMO = 16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [7:0]  qData = 8'h00;
  logic        qEmpty = 1'b1;
  logic        flush = 1'b0;
  logic        mReady = 1'b0;
  logic        qDeq;
  logic [31:0] mData;
  logic [2:0]  mCount;
  logic        mValid;
  logic [15:0] wordsOut;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] fifo[$];

  queue_word_packer #(
    .BYTES_PER_WORD (BPW),
    .TIMEOUT        (TMO)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_q_data    (qData),
    .i_q_empty   (qEmpty),
    .o_q_deq     (qDeq),
    .i_flush     (flush),
    .o_m_data    (mData),
    .o_m_count   (mCount),
    .o_m_valid   (mValid),
    .i_m_ready   (mReady),
    .o_words_out (wordsOut)
  );

  always #5 clk = ~clk;

  // Present the head of the queue model on the DUT inputs.
  task automatic refreshQueue();
    qEmpty = (fifo.size() == 0);
    qData  = qEmpty ? 8'h00 : fifo[0];
  endtask

  task automatic pushByte(input logic [7:0] b);
    fifo.push_back(b);
    refreshQueue();
  endtask

  // One clock: sample the pop request at the edge, then consume the byte.
  task automatic tick();
    logic popNow;
    @(posedge clk);
    popNow = qDeq;
    #1;
    if (popNow) begin
      compared++;
      if (fifo.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL pop_on_empty: q_deq=1 with queue empty, required no pop");
      end else begin
        void'(fifo.pop_front());
      end
    end
    refreshQueue();
  endtask

  task automatic waitValid(input int maxCycles, output int cycles);
    cycles = 0;
    while (mValid !== 1'b1 && cycles < maxCycles) begin
      tick();
      cycles++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1;
    rst_n = 1'b0;
    pushByte(8'hEE);
    #1;
    compared++;
    if (mValid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_m_valid: got %0b required 0", mValid); end
    compared++;
    if (mData !== 32'h0) begin mismatched++; $display("[TB] FAIL reset_m_data: got %h required 00000000", mData); end
    compared++;
    if (mCount !== 3'd0) begin mismatched++; $display("[TB] FAIL reset_m_count: got %0d required 0", mCount); end
    compared++;
    if (wordsOut !== 16'd0) begin mismatched++; $display("[TB] FAIL reset_words_out: got %0d required 0", wordsOut); end
    compared++;
    if (qDeq !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_q_deq: got %0b required 0", qDeq); end
    tick();
    fifo.delete();
    refreshQueue();
    rst_n = 1'b1;
  endtask

  task automatic test_full_word();
    int n;
    mReady = 1'b1;
    pushByte(8'h11); pushByte(8'h22); pushByte(8'h33); pushByte(8'h44);
    waitValid(10, n);
    compared++;
    if (n != 4) begin mismatched++; $display("[TB] FAIL full_latency: got %0d cycles required 4", n); end
    compared++;
    if (mData !== 32'h44332211) begin mismatched++; $display("[TB] FAIL full_data: got %h required 44332211", mData); end
    compared++;
    if (mCount !== 3'd4) begin mismatched++; $display("[TB] FAIL full_count: got %0d required 4", mCount); end
    tick();
    compared++;
    if (mValid !== 1'b0) begin mismatched++; $display("[TB] FAIL full_valid_drop: got %0b required 0", mValid); end
    compared++;
    if (wordsOut !== 16'd1) begin mismatched++; $display("[TB] FAIL full_words_out: got %0d required 1", wordsOut); end
  endtask

  task automatic test_timeout();
    int n;
    mReady = 1'b1;
    pushByte(8'hAA); pushByte(8'hBB); pushByte(8'hCC);
    repeat (3) tick();
    compared++;
    if (fifo.size() != 0) begin mismatched++; $display("[TB] FAIL timeout_pops: got %0d left required 0", fifo.size()); end
    // The last byte was popped at the edge just taken; count idle cycles from here.
    waitValid(40, n);
    compared++;
    if (n != TMO) begin mismatched++; $display("[TB] FAIL timeout_latency: got %0d cycles required %0d", n, TMO); end
    compared++;
    if (mData !== 32'h00CCBBAA) begin mismatched++; $display("[TB] FAIL timeout_data: got %h required 00ccbbaa", mData); end
    compared++;
    if (mCount !== 3'd3) begin mismatched++; $display("[TB] FAIL timeout_count: got %0d required 3", mCount); end
    tick();
    compared++;
    if (wordsOut !== 16'd2) begin mismatched++; $display("[TB] FAIL timeout_words_out: got %0d required 2", wordsOut); end
  endtask

  task automatic test_flush();
    int n;
    mReady = 1'b0;
    for (int i = 1; i <= 6; i++) pushByte(8'(i));
    tick(); tick();
    flush = 1'b1;
    #1;
    compared++;
    if (qDeq !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_blocks_pop: got %0b required 0", qDeq); end
    tick();
    flush = 1'b0;
    compared++;
    if (mValid !== 1'b1) begin mismatched++; $display("[TB] FAIL flush_valid: got %0b required 1", mValid); end
    compared++;
    if (mCount !== 3'd2) begin mismatched++; $display("[TB] FAIL flush_count: got %0d required 2", mCount); end
    compared++;
    if (mData !== 32'h00000201) begin mismatched++; $display("[TB] FAIL flush_data: got %h required 00000201", mData); end
    compared++;
    if (fifo.size() != 4) begin mismatched++; $display("[TB] FAIL flush_queue_left: got %0d required 4", fifo.size()); end
    mReady = 1'b1;
    tick();
    compared++;
    if (mValid !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_handshake: got %0b required 0", mValid); end
    waitValid(10, n);
    compared++;
    if (n != 4) begin mismatched++; $display("[TB] FAIL flush_next_latency: got %0d required 4", n); end
    compared++;
    if (mData !== 32'h06050403) begin mismatched++; $display("[TB] FAIL flush_next_data: got %h required 06050403", mData); end
    compared++;
    if (mCount !== 3'd4) begin mismatched++; $display("[TB] FAIL flush_next_count: got %0d required 4", mCount); end
    tick();
    compared++;
    if (wordsOut !== 16'd4) begin mismatched++; $display("[TB] FAIL flush_words_out: got %0d required 4", wordsOut); end
  endtask

  task automatic test_back_to_back();
    int n;
    mReady = 1'b0;
    for (int i = 0; i < 8; i++) pushByte(8'h10 + 8'(i));
    waitValid(10, n);
    compared++;
    if (n != 4) begin mismatched++; $display("[TB] FAIL bp_latency: got %0d required 4", n); end
    for (int c = 0; c < 10; c++) begin
      #1;
      compared++;
      if (qDeq !== 1'b0) begin mismatched++; $display("[TB] FAIL bp_q_deq cycle %0d: got %0b required 0", c, qDeq); end
      compared++;
      if (mValid !== 1'b1) begin mismatched++; $display("[TB] FAIL bp_valid cycle %0d: got %0b required 1", c, mValid); end
      compared++;
      if (mData !== 32'h13121110) begin mismatched++; $display("[TB] FAIL bp_data cycle %0d: got %h required 13121110", c, mData); end
      tick();
    end
    compared++;
    if (fifo.size() != 4) begin mismatched++; $display("[TB] FAIL bp_queue_left: got %0d required 4", fifo.size()); end
    mReady = 1'b1;
    tick();
    compared++;
    if (wordsOut !== 16'd5) begin mismatched++; $display("[TB] FAIL bp_words_out1: got %0d required 5", wordsOut); end
    waitValid(10, n);
    compared++;
    if (n != 4) begin mismatched++; $display("[TB] FAIL bp_second_latency: got %0d required 4", n); end
    compared++;
    if (mData !== 32'h17161514) begin mismatched++; $display("[TB] FAIL bp_second_data: got %h required 17161514", mData); end
    tick();
    compared++;
    if (wordsOut !== 16'd6) begin mismatched++; $display("[TB] FAIL bp_words_out2: got %0d required 6", wordsOut); end
  endtask

  task automatic test_flush_noop();
    int n;
    int seen;
    mReady = 1'b0;
    pushByte(8'h21); pushByte(8'h22); pushByte(8'h23); pushByte(8'h24);
    waitValid(10, n);
    compared++;
    if (mData !== 32'h24232221) begin mismatched++; $display("[TB] FAIL noop_word: got %h required 24232221", mData); end
    // Flush while holding a word: latched, then dropped since no bytes follow.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mReady = 1'b1;
    tick();
    compared++;
    if (wordsOut !== 16'd7) begin mismatched++; $display("[TB] FAIL noop_words_out: got %0d required 7", wordsOut); end
    seen = 0;
    repeat (20) begin tick(); if (mValid === 1'b1) seen++; end
    compared++;
    if (seen != 0) begin mismatched++; $display("[TB] FAIL noop_hold_flush: got %0d valid cycles required 0", seen); end
    // Flush with nothing accumulated is ignored.
    flush = 1'b1;
    tick();
    flush = 1'b0;
    seen = 0;
    repeat (20) begin tick(); if (mValid === 1'b1) seen++; end
    compared++;
    if (seen != 0) begin mismatched++; $display("[TB] FAIL noop_fill_flush: got %0d valid cycles required 0", seen); end
    // A stale pending flush would send this byte right away instead of at timeout.
    pushByte(8'h31);
    waitValid(40, n);
    compared++;
    if (n != TMO + 1) begin mismatched++; $display("[TB] FAIL noop_single_latency: got %0d required %0d", n, TMO + 1); end
    compared++;
    if (mCount !== 3'd1) begin mismatched++; $display("[TB] FAIL noop_single_count: got %0d required 1", mCount); end
    compared++;
    if (mData !== 32'h00000031) begin mismatched++; $display("[TB] FAIL noop_single_data: got %h required 00000031", mData); end
    tick();
    compared++;
    if (wordsOut !== 16'd8) begin mismatched++; $display("[TB] FAIL noop_words_out2: got %0d required 8", wordsOut); end
  endtask

  task automatic test_reset_mid();
    int n;
    mReady = 1'b0;
    pushByte(8'h41); pushByte(8'h42);
    tick(); tick();
    pushByte(8'h43);
    #1;
    compared++;
    if (qDeq !== 1'b1) begin mismatched++; $display("[TB] FAIL mid_pre_deq: got %0b required 1", qDeq); end
    rst_n = 1'b0;
    #1;
    compared++;
    if (qDeq !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_fill_deq: got %0b required 0", qDeq); end
    compared++;
    if (wordsOut !== 16'd0) begin mismatched++; $display("[TB] FAIL mid_fill_words: got %0d required 0", wordsOut); end
    tick();
    rst_n = 1'b1;
    // 41 and 42 were lost; 43 is still in the queue.
    pushByte(8'h51); pushByte(8'h52); pushByte(8'h53);
    waitValid(10, n);
    compared++;
    if (n != 4) begin mismatched++; $display("[TB] FAIL mid_fill_latency: got %0d required 4", n); end
    compared++;
    if (mData !== 32'h53525143) begin mismatched++; $display("[TB] FAIL mid_fill_data: got %h required 53525143", mData); end
    pushByte(8'h61);
    #1;
    rst_n = 1'b0;
    #1;
    compared++;
    if (mValid !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_hold_valid: got %0b required 0", mValid); end
    compared++;
    if (mData !== 32'h0) begin mismatched++; $display("[TB] FAIL mid_hold_data: got %h required 00000000", mData); end
    compared++;
    if (qDeq !== 1'b0) begin mismatched++; $display("[TB] FAIL mid_hold_deq: got %0b required 0", qDeq); end
    tick();
    rst_n = 1'b1;
    pushByte(8'h62); pushByte(8'h63); pushByte(8'h64);
    waitValid(10, n);
    compared++;
    if (n != 4) begin mismatched++; $display("[TB] FAIL mid_hold_latency: got %0d required 4", n); end
    compared++;
    if (mData !== 32'h64636261) begin mismatched++; $display("[TB] FAIL mid_hold_word: got %h required 64636261", mData); end
    mReady = 1'b1;
    tick();
    compared++;
    if (wordsOut !== 16'd1) begin mismatched++; $display("[TB] FAIL mid_words_out: got %0d required 1", wordsOut); end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_timeout();
    test_flush();
    test_back_to_back();
    test_flush_noop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Safety net in case the bench itself stops advancing.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog");
  end

endmodule
